// File: rtl/sprite_pixel_source_pkg.sv
// Shared types and constants for the sprite pixel source: pixel colour type,
// scan coordinate geometry and the update FSM state encoding.
package sprite_pixel_source_pkg;

    localparam int COORD_W   = 10;
    localparam int VISIBLE_W = 640;
    localparam int VISIBLE_H = 480;

    typedef logic [11:0]        pixel_t;
    typedef logic [COORD_W-1:0] coord_t;

    localparam pixel_t BLACK         = 12'h000;
    localparam pixel_t GREEN         = 12'h0F0;
    localparam pixel_t COLOR_DEFAULT = 12'hF00;

    typedef enum logic {
        IDLE,
        PENDING
    } upd_state_t;

    // One extra bit of headroom keeps start+size from wrapping, so a sprite
    // near the right or bottom edge is clipped instead of reappearing at 0.
    function automatic logic inSpan(input coord_t pos, input coord_t start,
                                    input int unsigned size);
        logic [COORD_W:0] p;
        logic [COORD_W:0] lo;
        logic [COORD_W:0] hi;
        p  = {1'b0, pos};
        lo = {1'b0, start};
        hi = lo + size[COORD_W:0];
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/sprite_pixel_source_mask_rom.sv
// Synchronous 1-bit transparency mask ROM, row-major (row*SPRITE_W+col).
// Only compiled and used when SPRITE_BITMAP_EN is defined.
`ifdef SPRITE_BITMAP_EN
module sprite_mask_rom #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned COLS   = 16
)(
    input  logic              clock,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_bit
);

    logic r_mem [DEPTH];

    // Checkerboard mask contents: a cell is opaque when row and column share parity.
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] = ((((i % int'(COLS)) ^ (i / int'(COLS))) & 1) == 0);
        end
    end

    always_ff @(posedge clock) begin
        o_bit <= r_mem[i_addr];
    end

endmodule
`endif

// File: rtl/sprite_pixel_source.sv
// One sprite lane for the pixel join: coverage/colour per scan coordinate and a
// frame-synchronised shadow update. SPRITE_BITMAP_EN adds a per-pixel mask ROM.
module sprite_pixel_source
    import sprite_pixel_source_pkg::*;
#(
    parameter int unsigned SPRITE_W = 16,
    parameter int unsigned SPRITE_H = 16,
    parameter pixel_t      COLOR    = COLOR_DEFAULT,
    parameter int          LEVEL    = 0
)(
    input  logic               clock,
    input  logic               reset,
    input  logic [9:0]         i_x,
    input  logic [9:0]         i_y,
    input  logic               i_frame_start,
    input  logic               i_upd_valid,
    output logic               o_upd_ready,
    input  logic [9:0]         i_upd_x,
    input  logic [9:0]         i_upd_y,
    input  logic signed [31:0] i_upd_level,
    input  logic               i_upd_visible,
    output logic               o_upd_done,
    output logic               o_enable,
    output logic signed [31:0] o_level,
    output logic [11:0]        o_pixel
);

    upd_state_t         r_state;
    coord_t             r_shadowX;
    coord_t             r_shadowY;
    logic signed [31:0] r_shadowLevel;
    logic               r_shadowVisible;
    logic               r_shadowFull;
    coord_t             r_actX;
    coord_t             r_actY;
    logic signed [31:0] r_actLevel;
    logic               r_actVisible;
    logic               r_updReady;
    logic               r_updDone;

    logic               r_cover;
    pixel_t             r_pixel;
    logic               w_cover;

    // Requests park in the shadow; the active copy only changes on frame_start
    // so a frame is always drawn from one consistent position.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_shadowX       <= '0;
            r_shadowY       <= '0;
            r_shadowLevel   <= '0;
            r_shadowVisible <= 1'b0;
            r_shadowFull    <= 1'b0;
            r_actX          <= '0;
            r_actY          <= '0;
            r_actLevel      <= LEVEL;
            r_actVisible    <= 1'b0;
            r_updReady      <= 1'b1;
            r_updDone       <= 1'b0;
        end else begin
            r_updDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_upd_valid) begin
                        r_shadowX       <= i_upd_x;
                        r_shadowY       <= i_upd_y;
                        r_shadowLevel   <= i_upd_level;
                        r_shadowVisible <= i_upd_visible;
                        r_shadowFull    <= 1'b1;
                        r_updReady      <= 1'b0;
                        r_state         <= PENDING;
                    end
                end
                PENDING: begin
                    if (i_frame_start && r_shadowFull) begin
                        r_actX       <= r_shadowX;
                        r_actY       <= r_shadowY;
                        r_actLevel   <= r_shadowLevel;
                        r_actVisible <= r_shadowVisible;
                        r_shadowFull <= 1'b0;
                        r_updDone    <= 1'b1;
                        r_updReady   <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_updReady <= 1'b1;
                end
            endcase
        end
    end

    assign w_cover = r_actVisible
                   & inSpan(i_x, r_actX, SPRITE_W)
                   & inSpan(i_y, r_actY, SPRITE_H);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cover <= 1'b0;
            r_pixel <= BLACK;
        end else begin
            r_cover <= w_cover;
            r_pixel <= w_cover ? COLOR : BLACK;
        end
    end

`ifdef SPRITE_BITMAP_EN
    localparam int unsigned ROM_DEPTH = SPRITE_W * SPRITE_H;
    localparam int unsigned ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    coord_t              w_col;
    coord_t              w_row;
    logic [ADDR_W-1:0]   w_romAddr;
    logic                w_maskBit;

    // The ROM register is the pixel stage for the mask, so it lines up with r_cover.
    assign w_col     = i_x - r_actX;
    assign w_row     = i_y - r_actY;
    assign w_romAddr = w_cover ? ADDR_W'(32'(w_row) * SPRITE_W + 32'(w_col)) : '0;

    sprite_mask_rom #(
        .DEPTH  (ROM_DEPTH),
        .ADDR_W (ADDR_W),
        .COLS   (SPRITE_W)
    ) u_maskRom (
        .clock  (clock),
        .i_addr (w_romAddr),
        .o_bit  (w_maskBit)
    );

    assign o_enable = r_cover & w_maskBit;
    assign o_pixel  = (r_cover & w_maskBit) ? r_pixel : BLACK;
`else
    assign o_enable = r_cover;
    assign o_pixel  = r_pixel;
`endif

    assign o_level     = r_actLevel;
    assign o_upd_ready = r_updReady;
    assign o_upd_done  = r_updDone;

endmodule

// File: tb/tb_sprite_pixel_source.sv
// Self-checking bench for sprite_pixel_source: expected enable/pixel values are
// queued when a coordinate is driven and compared when the DUT answers.
module tb_sprite_pixel_source;

    localparam int SW   = 16;
    localparam int SH   = 16;
    localparam int LVL0 = 0;

    logic               clock = 1'b0;
    logic               reset;
    logic [9:0]         i_x;
    logic [9:0]         i_y;
    logic               i_frame_start;
    logic               i_upd_valid;
    logic               o_upd_ready;
    logic [9:0]         i_upd_x;
    logic [9:0]         i_upd_y;
    logic signed [31:0] i_upd_level;
    logic               i_upd_visible;
    logic               o_upd_done;
    logic               o_enable;
    logic signed [31:0] o_level;
    logic [11:0]        o_pixel;

    typedef struct packed {
        logic        en;
        logic [11:0] pix;
    } exp_t;

    exp_t expQ[$];
    int   checks    = 0;
    int   failures  = 0;
    int   doneCount = 0;

    int   mX, mY, mLevel;
    bit   mVis;
    int   sX, sY, sLevel;
    bit   sVis;

    sprite_pixel_source #(
        .SPRITE_W (SW),
        .SPRITE_H (SH),
        .COLOR    (12'hF00),
        .LEVEL    (LVL0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_x           (i_x),
        .i_y           (i_y),
        .i_frame_start (i_frame_start),
        .i_upd_valid   (i_upd_valid),
        .o_upd_ready   (o_upd_ready),
        .i_upd_x       (i_upd_x),
        .i_upd_y       (i_upd_y),
        .i_upd_level   (i_upd_level),
        .i_upd_visible (i_upd_visible),
        .o_upd_done    (o_upd_done),
        .o_enable      (o_enable),
        .o_level       (o_level),
        .o_pixel       (o_pixel)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && o_upd_done) doneCount++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t model(input int px, input int py);
        exp_t e;
        logic hit;
        hit = mVis && (px >= mX) && (px < mX + SW) && (py >= mY) && (py < mY + SH);
`ifdef SPRITE_BITMAP_EN
        if (hit && ((((px - mX) ^ (py - mY)) & 1) != 0)) hit = 1'b0;
`endif
        e.en  = hit;
        e.pix = hit ? 12'hF00 : 12'h000;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int px, input int py);
        exp_t e;
        i_x = 10'(px);
        i_y = 10'(py);
        expQ.push_back(model(px, py));
        @(posedge clock); #1;
        e = expQ.pop_front();
        checkOutput($sformatf("enable@%0d,%0d", px, py), 32'(o_enable), 32'(e.en));
        checkOutput($sformatf("pixel@%0d,%0d", px, py), 32'(o_pixel), 32'(e.pix));
    endtask

    task automatic scanBox(input int x0, input int x1, input int y0, input int y1, input int step);
        for (int yy = y0; yy <= y1; yy += step)
            for (int xx = x0; xx <= x1; xx += step)
                applyStimulus(xx, yy);
    endtask

    task automatic sendRequest(input int ux, input int uy, input int lvl, input bit vis);
        checkOutput("ready_before_req", 32'(o_upd_ready), 32'd1);
        i_upd_valid   = 1'b1;
        i_upd_x       = 10'(ux);
        i_upd_y       = 10'(uy);
        i_upd_level   = lvl;
        i_upd_visible = vis;
        @(posedge clock); #1;
        i_upd_valid = 1'b0;
        sX = ux; sY = uy; sLevel = lvl; sVis = vis;
        checkOutput("ready_after_req", 32'(o_upd_ready), 32'd0);
    endtask

    task automatic pulseFrame(input bit expectCommit);
        int d0;
        d0 = doneCount;
        i_frame_start = 1'b1;
        @(posedge clock); #1;
        i_frame_start = 1'b0;
        checkOutput("done_pulse", 32'(o_upd_done), 32'(expectCommit));
        if (expectCommit) begin
            mX = sX; mY = sY; mLevel = sLevel; mVis = sVis;
        end
        @(posedge clock); #1;
        checkOutput("done_low", 32'(o_upd_done), 32'd0);
        checkOutput("done_count", 32'(doneCount - d0), 32'(expectCommit));
        checkOutput("level", o_level, 32'(mLevel));
        checkOutput("ready_idle", 32'(o_upd_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        i_x = '0; i_y = '0; i_frame_start = 1'b0; i_upd_valid = 1'b0;
        i_upd_x = '0; i_upd_y = '0; i_upd_level = 0; i_upd_visible = 1'b0;
        mX = 0; mY = 0; mLevel = LVL0; mVis = 1'b0;
        sX = 0; sY = 0; sLevel = 0; sVis = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_enable", 32'(o_enable), 32'd0);
        checkOutput("rst_pixel", 32'(o_pixel), 32'd0);
        checkOutput("rst_level", o_level, 32'(LVL0));
        checkOutput("rst_ready", 32'(o_upd_ready), 32'd1);
        checkOutput("rst_done", 32'(o_upd_done), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        $display("[TB] default state frame scan");
        scanBox(0, 639, 0, 479, 8);
        scanBox(630, 639, 470, 479, 3);
        checkOutput("idle_level", o_level, 32'(LVL0));
        checkOutput("idle_ready", 32'(o_upd_ready), 32'd1);

        $display("[TB] basic update at 100,50");
        sendRequest(100, 50, 3, 1'b1);
        scanBox(95, 120, 45, 70, 5);
        pulseFrame(1'b1);
        scanBox(95, 120, 45, 70, 1);
        pulseFrame(1'b0);

        $display("[TB] request coincident with frame_start");
        checkOutput("ready_before_coinc", 32'(o_upd_ready), 32'd1);
        i_upd_valid = 1'b1; i_frame_start = 1'b1;
        i_upd_x = 10'd300; i_upd_y = 10'd100; i_upd_level = 9; i_upd_visible = 1'b1;
        @(posedge clock); #1;
        i_upd_valid = 1'b0; i_frame_start = 1'b0;
        sX = 300; sY = 100; sLevel = 9; sVis = 1'b1;
        checkOutput("coinc_ready", 32'(o_upd_ready), 32'd0);
        checkOutput("coinc_done", 32'(o_upd_done), 32'd0);
        checkOutput("coinc_level", o_level, 32'd3);
        i_upd_valid = 1'b1;
        i_upd_x = 10'd10; i_upd_y = 10'd10; i_upd_level = 2; i_upd_visible = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            checkOutput("pending_ready", 32'(o_upd_ready), 32'd0);
        end
        i_upd_valid = 1'b0;
        scanBox(98, 118, 48, 68, 4);
        pulseFrame(1'b1);
        checkOutput("commit_first_level", o_level, 32'd9);
        scanBox(295, 320, 95, 120, 1);
        scanBox(0, 30, 0, 30, 3);

        $display("[TB] clipping at bottom right");
        sendRequest(630, 475, 5, 1'b1);
        pulseFrame(1'b1);
        scanBox(620, 639, 465, 479, 1);
        scanBox(0, 5, 0, 10, 1);
        scanBox(0, 5, 470, 479, 1);
        scanBox(625, 639, 0, 10, 1);

        $display("[TB] reset while pending");
        sendRequest(200, 200, 7, 1'b1);
        reset = 1'b1;
        #2;
        checkOutput("pend_rst_ready", 32'(o_upd_ready), 32'd1);
        checkOutput("pend_rst_done", 32'(o_upd_done), 32'd0);
        checkOutput("pend_rst_level", o_level, 32'(LVL0));
        checkOutput("pend_rst_enable", 32'(o_enable), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        mX = 0; mY = 0; mLevel = LVL0; mVis = 1'b0;
        pulseFrame(1'b0);
        scanBox(195, 220, 195, 220, 5);
        scanBox(0, 20, 0, 20, 4);

        $display("[TB] update after reset recovery");
        sendRequest(0, 0, 1, 1'b1);
        pulseFrame(1'b1);
        scanBox(0, 20, 0, 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
